// File: rtl/simon_playback_sequencer_pkg.sv
// Shared definitions for the Simon playback sequencer: lamp color codes and
// the playback state type.
package simon_pkg;

  localparam logic [1:0] COLOR_RED    = 2'b00;
  localparam logic [1:0] COLOR_BLUE   = 2'b01;
  localparam logic [1:0] COLOR_GREEN  = 2'b10;
  localparam logic [1:0] COLOR_YELLOW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ON,
    ST_OFF,
    ST_FINISH
  } play_state_t;

endpackage

// File: rtl/simon_playback_sequencer_if.sv
// Controller handshake, sequence-memory read port and lamp drives of the
// playback sequencer; the sequencer is the slave side.
interface simon_playback_sequencer_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] seq_len;
  logic [1:0]        mem_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              r_out;
  logic              b_out;
  logic              g_out;
  logic              y_out;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, seq_len, mem_data,
    input  rd_addr, r_out, b_out, g_out, y_out, busy, done
  );

  modport slave (
    input  start, abort, seq_len, mem_data,
    output rd_addr, r_out, b_out, g_out, y_out, busy, done
  );
endinterface

// File: rtl/simon_playback_sequencer_dwell_timer.sv
// Loadable down-counter with a zero flag; times both the lamp-on and the
// lamp-off dwell of the playback sequencer.
module simon_dwell_timer #(
  parameter int W = 3
) (
  input  logic         ph1,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Plays the stored Simon color sequence on the four lamps with fixed on/off
// dwell times, under a start/abort/done handshake from the game controller.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_LOAD   | rd_addr = idx, memory data captured into color_q
// ST_ON     | lamp for color_q lit for ON_CYCLES cycles
// ST_OFF    | all lamps dark for OFF_CYCLES cycles
// ST_FINISH | done pulse, back to idle next cycle
module simon_playback_sequencer
  import simon_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input logic                        ph1,
  input logic                        reset,
  simon_playback_sequencer_if.slave  bus
);

  if (ON_CYCLES < 1) begin : g_bad_on
    $error("ON_CYCLES must be at least 1");
  end
  if (OFF_CYCLES < 1) begin : g_bad_off
    $error("OFF_CYCLES must be at least 1");
  end

  localparam int DWELL_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW        = $clog2(DWELL_MAX + 1);

  play_state_t       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] len_q;
  logic [1:0]        color_q;
  logic              busy_q;
  logic              done_q;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;

  // Timer is steered purely by the current state; an abort leaves it alone
  // since every later entry reloads it before use.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    if (!bus.abort) begin
      case (state_q)
        ST_LOAD: begin
          tmr_load = 1'b1;
          tmr_val  = TW'(ON_CYCLES - 1);
        end
        ST_ON: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(OFF_CYCLES - 1);
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_OFF:  tmr_dec = 1'b1;
        default: ;
      endcase
    end
  end

  simon_dwell_timer #(
    .W (TW)
  ) u_dwell_timer (
    .ph1      (ph1),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      color_q <= COLOR_RED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != ST_IDLE) && bus.abort) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              busy_q <= 1'b1;
              idx_q  <= '0;
              if (bus.seq_len != '0) begin
                len_q   <= bus.seq_len;
                state_q <= ST_LOAD;
              end else begin
                done_q  <= 1'b1;
                state_q <= ST_FINISH;
              end
            end
          end
          ST_LOAD: begin
            color_q <= bus.mem_data;
            state_q <= ST_ON;
          end
          ST_ON: begin
            if (tmr_zero) begin
              state_q <= ST_OFF;
            end
          end
          ST_OFF: begin
            if (tmr_zero) begin
              // len_q is at least 1 here, so the subtraction cannot wrap
              if (idx_q == (len_q - ADDR_W'(1))) begin
                done_q  <= 1'b1;
                state_q <= ST_FINISH;
              end else begin
                idx_q   <= idx_q + ADDR_W'(1);
                state_q <= ST_LOAD;
              end
            end
          end
          ST_FINISH: begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  logic lamp_on;
  assign lamp_on = (state_q == ST_ON);

  assign bus.r_out   = lamp_on && (color_q == COLOR_RED);
  assign bus.b_out   = lamp_on && (color_q == COLOR_BLUE);
  assign bus.g_out   = lamp_on && (color_q == COLOR_GREEN);
  assign bus.y_out   = lamp_on && (color_q == COLOR_YELLOW);
  assign bus.rd_addr = idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Self-checking bench for simon_playback_sequencer: a timeline model of the
// playback checked every cycle, plus directed literal checks and random traffic.
module tb_simon_playback_sequencer;

  localparam int ADDR_W = 7;
  localparam int ON     = 4;
  localparam int OFF    = 2;
  localparam int P      = 1 + ON + OFF;

  logic ph1   = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] mem [0:127];

  simon_playback_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  simon_playback_sequencer #(
    .ADDR_W     (ADDR_W),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_data = mem[bus.rd_addr];

  logic [3:0] lamps;
  assign lamps = {bus.y_out, bus.g_out, bus.b_out, bus.r_out};

  always #5 ph1 = ~ph1;
  always @(posedge ph1) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Model: a run is a timeline. m_t counts cycles since the accepting edge;
  // each entry occupies P cycles (load, ON lit, OFF dark), then one done cycle.
  bit m_active = 1'b0;
  int m_t = 0;
  int m_n = 0;

  always @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (bus.abort) begin
        m_active = 1'b0;
      end else begin
        m_t++;
        if (m_t > m_n * P) m_active = 1'b0;
      end
    end else if (bus.start) begin
      m_active = 1'b1;
      m_t      = 0;
      m_n      = int'(bus.seq_len);
    end
  end

  function automatic void model_expect(output logic [3:0] e_lamps, output logic [ADDR_W-1:0] e_addr,
                                       output logic e_busy, output logic e_done);
    int ph;
    e_lamps = 4'b0000;
    e_addr  = '0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    if (m_active) begin
      e_busy = 1'b1;
      if (m_t == m_n * P) begin
        e_done = 1'b1;
        e_addr = (m_n == 0) ? '0 : ADDR_W'(m_n - 1);
      end else begin
        e_addr = ADDR_W'(m_t / P);
        ph     = m_t % P;
        if (ph >= 1 && ph <= ON) e_lamps = 4'b0001 << mem[m_t / P];
      end
    end
  endfunction

  always @(negedge ph1) begin
    logic [3:0]        el;
    logic [ADDR_W-1:0] ea;
    logic              eb, ed;
    model_expect(el, ea, eb, ed);
    cmp("lamps", 32'(lamps), 32'(el));
    cmp("rd_addr", 32'(bus.rd_addr), 32'(ea));
    cmp("busy", 32'(bus.busy), 32'(eb));
    cmp("done", 32'(bus.done), 32'(ed));
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge ph1);
  endtask

  task automatic start_run(input int n, output int k);
    @(negedge ph1);
    bus.seq_len = ADDR_W'(n);
    bus.start   = 1'b1;
    k           = cyc + 1;
    @(negedge ph1);
    bus.start   = 1'b0;
  endtask

  initial begin
    int k, k2;
    logic [3:0] one_hot;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.seq_len = '0;
    for (int i = 0; i < 128; i++) mem[i] = 2'($urandom);

    #1;
    cmp("lit_reset_lamps", 32'(lamps), 32'h0);
    cmp("lit_reset_busy", 32'(bus.busy), 32'h0);
    cmp("lit_reset_done", 32'(bus.done), 32'h0);
    cmp("lit_reset_addr", 32'(bus.rd_addr), 32'h0);
    repeat (3) @(negedge ph1);
    reset = 1'b1;
    repeat (2) @(negedge ph1);

    // Three colors green, blue, yellow; a second start mid-run is ignored
    mem[0] = 2'b10; mem[1] = 2'b01; mem[2] = 2'b11;
    start_run(3, k);
    wait_until(k + 3);
    cmp("lit_s1_green", 32'(lamps), 32'h4);
    wait_until(k + 5);
    cmp("lit_s1_dark_a", 32'(lamps), 32'h0);
    wait_until(k + 6);
    cmp("lit_s1_dark_b", 32'(lamps), 32'h0);
    wait_until(k + 8);
    cmp("lit_s1_blue", 32'(lamps), 32'h2);
    cmp("lit_s1_addr1", 32'(bus.rd_addr), 32'h1);
    bus.start = 1'b1; bus.seq_len = ADDR_W'(1);
    wait_until(k + 9);
    bus.start = 1'b0;
    wait_until(k + 17);
    cmp("lit_s1_yellow", 32'(lamps), 32'h8);
    cmp("lit_s1_addr2", 32'(bus.rd_addr), 32'h2);
    wait_until(k + 20);
    cmp("lit_s1_no_done", 32'(bus.done), 32'h0);
    wait_until(k + 21);
    cmp("lit_s1_done", 32'(bus.done), 32'h1);
    cmp("lit_s1_busy_fin", 32'(bus.busy), 32'h1);
    wait_until(k + 22);
    cmp("lit_s1_idle_busy", 32'(bus.busy), 32'h0);
    cmp("lit_s1_idle_done", 32'(bus.done), 32'h0);

    // Empty sequence
    start_run(0, k);
    cmp("lit_s2_done", 32'(bus.done), 32'h1);
    cmp("lit_s2_addr", 32'(bus.rd_addr), 32'h0);
    cmp("lit_s2_lamps", 32'(lamps), 32'h0);
    wait_until(k + 1);
    cmp("lit_s2_busy_low", 32'(bus.busy), 32'h0);

    // Abort during the second ON, then replay from the first entry
    start_run(3, k);
    wait_until(k + 9);
    one_hot = 4'b0001 << mem[1];
    cmp("lit_s3_second_on", 32'(lamps), 32'(one_hot));
    bus.abort = 1'b1;
    wait_until(k + 10);
    bus.abort = 1'b0;
    cmp("lit_s3_abort_busy", 32'(bus.busy), 32'h0);
    cmp("lit_s3_abort_lamps", 32'(lamps), 32'h0);
    wait_until(k + 25);
    cmp("lit_s3_no_done", 32'(bus.done), 32'h0);
    start_run(3, k2);
    wait_until(k2 + 2);
    one_hot = 4'b0001 << mem[0];
    cmp("lit_s3_replay", 32'(lamps), 32'(one_hot));
    cmp("lit_s3_replay_addr", 32'(bus.rd_addr), 32'h0);
    wait_until(k2 + 23);

    // Asynchronous reset in the middle of an OFF dwell
    start_run(2, k);
    wait_until(k + 5);
    #2 reset = 1'b0;
    #1;
    cmp("lit_s4_rst_busy", 32'(bus.busy), 32'h0);
    cmp("lit_s4_rst_lamps", 32'(lamps), 32'h0);
    cmp("lit_s4_rst_done", 32'(bus.done), 32'h0);
    cmp("lit_s4_rst_addr", 32'(bus.rd_addr), 32'h0);
    repeat (2) @(negedge ph1);
    reset = 1'b1;
    repeat (4) @(negedge ph1);
    cmp("lit_s4_wait_start", 32'(bus.busy), 32'h0);

    // Longest sequence
    for (int i = 0; i < 128; i++) mem[i] = 2'($urandom);
    start_run(127, k);
    wait_until(k + 888);
    cmp("lit_s5_last_addr", 32'(bus.rd_addr), 32'd126);
    cmp("lit_s5_not_done", 32'(bus.done), 32'h0);
    wait_until(k + 889);
    cmp("lit_s5_done", 32'(bus.done), 32'h1);
    cmp("lit_s5_done_addr", 32'(bus.rd_addr), 32'd126);
    wait_until(k + 891);

    // Random start/abort/seq_len traffic against the model
    for (int i = 0; i < 128; i++) mem[i] = 2'($urandom);
    for (int i = 0; i < 800; i++) begin
      @(negedge ph1);
      bus.start   = ($urandom % 6) == 0;
      bus.seq_len = ADDR_W'($urandom_range(0, 6));
      bus.abort   = ($urandom % 40) == 0;
    end
    @(negedge ph1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (60) @(negedge ph1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
